// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  localparam int UART_DEFAULT_CLKS_PER_BIT = 104;
  localparam int UART_DATA_BITS            = 8;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the serial input; both flops reset to the idle-high level.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, LSB-first assembly, valid / frame_error strobes.
// Define UART_RX_SYNC_EN to pass rx through a 2-flop synchronizer (adds 2 cycles of latency).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  output logic                      busy,
  output logic                      frame_error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

  logic w_rs;

`ifdef UART_RX_SYNC_EN
  uart_sync2 u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (rx),
    .o_q  (w_rs)
  );
`else
  assign w_rs = rx;
`endif

  uart_rx_state_t            r_state;
  uart_rx_state_t            w_state_nxt;
  logic [CW-1:0]             r_cnt;
  logic [2:0]                r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] r_data;
  logic                      r_valid;
  logic                      r_ferr;
  logic                      r_rs_prev;
  logic                      w_cnt_clr;
  logic                      w_cnt_inc;
  logic                      w_shift;
  logic                      w_load;
  logic                      w_ferr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // IDLE waits for a high-to-low edge so a held-low (break) line cannot retrigger.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_shift     = 1'b0;
    w_load      = 1'b0;
    w_ferr      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_rs_prev && !w_rs) begin
          w_state_nxt = START;
          w_cnt_clr   = 1'b1;
        end
      end
      START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = w_rs ? IDLE : DATA;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_clr = 1'b1;
          w_shift   = 1'b1;
          if (r_bit_idx == LAST_BIT) w_state_nxt = STOP;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = IDLE;
          w_load      = w_rs;
          w_ferr      = !w_rs;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_rs_prev <= 1'b1;
    end else begin
      r_rs_prev <= w_rs;
      r_valid   <= w_load;
      r_ferr    <= w_ferr;
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
      if (r_state == START) r_bit_idx <= '0;
      else if (w_shift)     r_bit_idx <= r_bit_idx + 1'b1;
      if (w_shift) r_shift <= {w_rs, r_shift[UART_DATA_BITS-1:1]};
      if (w_load)  r_data  <= r_shift;
    end
  end

  assign data        = r_data;
  assign valid       = r_valid;
  assign frame_error = r_ferr;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame table with random entries plus glitch, break, reset and latency cases.
// Honours UART_RX_SYNC_EN by shifting every expected event by the synchronizer delay.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       frame_error;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .busy       (busy),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         isErr;
    logic [7:0] d;
  } event_t;

  typedef struct {
    logic [7:0] b;
    bit         stopOk;
    int         gap;
    logic [7:0] expData;
  } vec_t;

  event_t     gotQ[$];
  event_t     expQ[$];
  int         nChecks = 0;
  int         nErrors = 0;
  logic [7:0] modelData = 8'h00;

  // Collects every strobe; strobes must never coincide.
  always @(negedge clk) begin
    if (rst_n && (valid || frame_error)) begin
      nChecks++;
      if (valid && frame_error) begin
        nErrors++;
        $display("[TB] FAIL strobeExclusive at cycle %0d: valid=%0b frame_error=%0b, required not both", cyc, valid, frame_error);
      end
      gotQ.push_back('{cyc, frame_error, data});
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Holds the line at v for n clock cycles; always returns 1 time unit after a rising edge.
  task automatic driveBit(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one frame and records the strobe the framing rules predict for it.
  task automatic applyStimulus(input logic [7:0] b, input bit stopOk, input int gap);
    event_t e;
    int     fallCyc;
    fallCyc = cyc;
    driveBit(1'b0, CPB);
    for (int i = 0; i < 8; i++) driveBit(b[i], CPB);
    driveBit(stopOk, CPB);
    if (stopOk) modelData = b;
    e.cyc   = fallCyc + 1 + SYNC_LAT + HALF + 9 * CPB;
    e.isErr = !stopOk;
    e.d     = modelData;
    expQ.push_back(e);
    if (gap > 0) driveBit(1'b1, gap);
  endtask

  task automatic compareEvents(input string tag);
    while (expQ.size() > 0) begin
      event_t e;
      event_t g;
      e = expQ.pop_front();
      if (gotQ.size() == 0) begin
        nChecks++;
        nErrors++;
        $display("[TB] FAIL %s_missing: no strobe seen, expected one at cycle %0d", tag, e.cyc);
      end else begin
        g = gotQ.pop_front();
        checkOutput({tag, "_cycle"}, g.cyc, e.cyc);
        checkOutput({tag, "_isErr"}, {31'd0, g.isErr}, {31'd0, e.isErr});
        checkOutput({tag, "_data"}, {24'd0, g.d}, {24'd0, e.d});
      end
    end
    checkOutput({tag, "_extraStrobes"}, gotQ.size(), 0);
    gotQ.delete();
  endtask

  vec_t tbl[$];

  initial begin
    vec_t       v;
    logic [7:0] runData;
    int         t0;

    // Reset state
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_data", {24'd0, data}, 32'h00);
    checkOutput("reset_valid", {31'd0, valid}, 0);
    checkOutput("reset_busy", {31'd0, busy}, 0);
    checkOutput("reset_ferr", {31'd0, frame_error}, 0);
    rst_n = 1'b1;
    driveBit(1'b1, 4);

    // Frame table: fixed corner frames, then random ones
    tbl.push_back('{8'h55, 1'b1, 4, 8'h00});
    tbl.push_back('{8'hA3, 1'b1, 0, 8'h00});
    tbl.push_back('{8'h0F, 1'b1, 4, 8'h00});
    tbl.push_back('{8'h55, 1'b1, 3, 8'h00});
    tbl.push_back('{8'h3C, 1'b0, 5, 8'h00});
    for (int i = 0; i < 8; i++) begin
      v.b      = 8'($urandom);
      v.stopOk = ($urandom_range(0, 3) != 0);
      v.gap    = v.stopOk ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 3));
      v.expData = 8'h00;
      tbl.push_back(v);
    end
    runData = modelData;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].stopOk) runData = tbl[i].b;
      tbl[i].expData = runData;
    end

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].b, tbl[i].stopOk, tbl[i].gap);
      checkOutput($sformatf("table%0d_data", i), {24'd0, data}, {24'd0, tbl[i].expData});
      checkOutput($sformatf("table%0d_busyAfter", i), {31'd0, busy}, 0);
    end
    driveBit(1'b1, 2 * CPB);
    compareEvents("table");

    // Short low pulse: start bit rejected at mid-bit
    driveBit(1'b0, HALF / 2);
    checkOutput("glitch_busyHigh", {31'd0, busy}, 1);
    driveBit(1'b1, HALF + SYNC_LAT + 4);
    checkOutput("glitch_busyLow", {31'd0, busy}, 0);
    driveBit(1'b1, CPB);
    compareEvents("glitch");
    checkOutput("glitch_data", {24'd0, data}, {24'd0, modelData});

    // Break: one frame_error, no restart until the line goes high again
    begin
      event_t e;
      e.cyc   = cyc + 1 + SYNC_LAT + HALF + 9 * CPB;
      e.isErr = 1'b1;
      e.d     = modelData;
      expQ.push_back(e);
    end
    driveBit(1'b0, 12 * CPB);
    checkOutput("break_busyDuringLow", {31'd0, busy}, 0);
    driveBit(1'b1, 2 * CPB);
    compareEvents("break");
    applyStimulus(8'hC6, 1'b1, 2 * CPB);
    compareEvents("afterBreak");
    checkOutput("afterBreak_data", {24'd0, data}, 32'hC6);

    // Asynchronous reset after data bit 3 of 0x81
    begin
      logic [7:0] b;
      b = 8'h81;
      driveBit(1'b0, CPB);
      for (int i = 0; i < 4; i++) driveBit(b[i], CPB);
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midReset_data", {24'd0, data}, 32'h00);
    checkOutput("midReset_busy", {31'd0, busy}, 0);
    checkOutput("midReset_valid", {31'd0, valid}, 0);
    checkOutput("midReset_ferr", {31'd0, frame_error}, 0);
    modelData = 8'h00;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    driveBit(1'b1, 2 * CPB);
    compareEvents("midReset");
    applyStimulus(8'h81, 1'b1, 2 * CPB);
    compareEvents("afterReset");
    checkOutput("afterReset_data", {24'd0, data}, 32'h81);

    // Strobe latency from the edge T on which the receiver first sees the line low
    t0 = cyc;
    applyStimulus(8'hFF, 1'b1, 2 * CPB);
    if (gotQ.size() == 0) begin
      nChecks++;
      nErrors++;
      $display("[TB] FAIL latency: no strobe seen, expected one %0d cycles after T", HALF + 9 * CPB + 1);
    end else begin
      checkOutput("latency", gotQ[0].cyc + 1 - (t0 + 1 + SYNC_LAT), HALF + 9 * CPB + 1);
    end
    compareEvents("latencyFrame");
    checkOutput("latency_data", {24'd0, data}, 32'hFF);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
